// File: rtl/sensor_sequencer_pkg.sv
// Shared configuration for the pixel sensor sequencer: array geometry defaults and
// the sequencer state encoding, also used by the bench for state checks.
package sensor_sequencer_pkg;

  localparam int unsigned PIXEL_BITS         = 8;
  localparam int unsigned PIXEL_ARRAY_HEIGHT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StExpose,
    StConvert,
    StRead,
    StDone
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sensor_sequencer_phase_counter.sv
// Loadable down-counter with a terminal-count flag; times the erase, exposure and
// conversion phases. A phase of N cycles is loaded with N-1 and ends when tc_o is seen.
module phase_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/sensor_sequencer.sv
// Frame sequencer: erase -> expose -> ramp-ADC convert -> row readout -> done.
// All outputs come straight from flops so the async reset clears them at once.
module sensor_sequencer
  import sensor_sequencer_pkg::*;
#(
  parameter int unsigned ROWS         = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned ADC_BITS     = PIXEL_BITS,
  parameter int unsigned ERASE_CYCLES = 5,
  parameter int unsigned EXP_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_req,
  input  logic [EXP_WIDTH-1:0]    exp_cycles,
  input  logic                    buf_ready,
  output logic                    erase,
  output logic                    expose,
  output logic                    convert,
  output logic [ADC_BITS-1:0]     adc_count,
  output logic                    row_valid,
  output logic [$clog2(ROWS)-1:0] row_sel,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned CntW = max3(EXP_WIDTH, ADC_BITS, $clog2(ERASE_CYCLES + 1));
  localparam int unsigned RowW = $clog2(ROWS);

  localparam logic [CntW-1:0] EraseLoad = CntW'(ERASE_CYCLES - 1);
  localparam logic [CntW-1:0] ConvLoad  = CntW'((2 ** ADC_BITS) - 1);
  localparam logic [RowW-1:0] LastRow   = RowW'(ROWS - 1);

  seq_state_e           state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [ADC_BITS-1:0]  adc_q, adc_d;
  logic [RowW-1:0]      row_q, row_d;
  logic                 cnt_load;
  logic [CntW-1:0]      cnt_value;
  logic                 cnt_tc;
  logic                 erase_q, expose_q, convert_q, row_valid_q, frame_done_q, busy_q;

  phase_counter #(
    .Width (CntW)
  ) u_phase_counter (
    .clk_i        (clk),
    .rst_ni       (reset),
    .load_i       (cnt_load),
    .load_value_i (cnt_value),
    .tc_o         (cnt_tc)
  );

  // Next-state logic; the phase counter is loaded on entry to each timed phase.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    adc_d     = adc_q;
    row_d     = row_q;
    cnt_load  = 1'b0;
    cnt_value = '0;
    unique case (state_q)
      StIdle: begin
        if (frame_req) begin
          // A zero exposure request still exposes for one cycle.
          exp_d     = (exp_cycles == '0) ? EXP_WIDTH'(1) : exp_cycles;
          cnt_load  = 1'b1;
          cnt_value = EraseLoad;
          state_d   = StErase;
        end
      end
      StErase: begin
        if (cnt_tc) begin
          cnt_load  = 1'b1;
          cnt_value = CntW'(exp_q) - CntW'(1);
          state_d   = StExpose;
        end
      end
      StExpose: begin
        if (cnt_tc) begin
          cnt_load  = 1'b1;
          cnt_value = ConvLoad;
          state_d   = StConvert;
        end
      end
      StConvert: begin
        if (cnt_tc) begin
          adc_d   = '0;
          state_d = StRead;
        end else begin
          adc_d = adc_q + ADC_BITS'(1);
        end
      end
      StRead: begin
        if (buf_ready) begin
          if (row_q == LastRow) begin
            row_d   = '0;
            state_d = StDone;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered phase outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      exp_q        <= '0;
      adc_q        <= '0;
      row_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      adc_q        <= adc_d;
      row_q        <= row_d;
      erase_q      <= (state_d == StErase);
      expose_q     <= (state_d == StExpose);
      convert_q    <= (state_d == StConvert);
      row_valid_q  <= (state_d == StRead);
      frame_done_q <= (state_d == StDone);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign adc_count  = adc_q;
  assign row_valid  = row_valid_q;
  assign row_sel    = row_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sensor_sequencer.sv
// Bench for sensor_sequencer: a timeline model (queue of expected per-cycle outputs)
// checked every cycle, a table of whole-frame vectors, hand-written corner sequences
// and a randomized run.
module tb_sensor_sequencer;
  import sensor_sequencer_pkg::*;

  localparam int ROWS  = 4;
  localparam int ADCB  = 8;
  localparam int ERASE = 5;
  localparam int EXPW  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_req = 1'b0;
  logic [EXPW-1:0] exp_cycles = '0;
  logic            buf_ready = 1'b0;
  logic            erase, expose, convert, row_valid, frame_done, busy;
  logic [ADCB-1:0] adc_count;
  logic [1:0]      row_sel;

  sensor_sequencer #(
    .ROWS         (ROWS),
    .ADC_BITS     (ADCB),
    .ERASE_CYCLES (ERASE),
    .EXP_WIDTH    (EXPW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_req  (frame_req),
    .exp_cycles (exp_cycles),
    .buf_ready  (buf_ready),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .adc_count  (adc_count),
    .row_valid  (row_valid),
    .row_sel    (row_sel),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            erase;
    logic            expose;
    logic            convert;
    logic [ADCB-1:0] adc;
    logic            row_valid;
    logic [1:0]      row_sel;
    logic            frame_done;
    logic            busy;
  } outs_t;

  typedef enum {MIdle, MTimeline, MRead, MDone} mphase_e;

  typedef struct {
    int e;
    int stall_row;
    int stall_len;
    bit poke;
    int len;
    int expose_n;
  } vec_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  outs_t   cur = '0;
  outs_t   tl[$];
  mphase_e m_phase = MIdle;
  int      m_row = 0;

  function automatic void check(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic outs_t read_outs(input int row);
    outs_t o;
    o           = '0;
    o.row_valid = 1'b1;
    o.row_sel   = 2'(row);
    o.busy      = 1'b1;
    return o;
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    outs_t o;
    int    e;
    if (!reset) begin
      m_phase = MIdle;
      tl.delete();
      cur = '0;
      return;
    end
    case (m_phase)
      MIdle: begin
        cur = '0;
        if (frame_req) begin
          e = (exp_cycles == 0) ? 1 : int'(exp_cycles);
          for (int i = 0; i < ERASE; i++) begin
            o = '0; o.erase = 1'b1; o.busy = 1'b1; tl.push_back(o);
          end
          for (int i = 0; i < e; i++) begin
            o = '0; o.expose = 1'b1; o.busy = 1'b1; tl.push_back(o);
          end
          for (int i = 0; i < (1 << ADCB); i++) begin
            o = '0; o.convert = 1'b1; o.adc = ADCB'(i); o.busy = 1'b1; tl.push_back(o);
          end
          cur = tl.pop_front();
          m_phase = MTimeline;
        end
      end
      MTimeline: begin
        if (tl.size() > 0) begin
          cur = tl.pop_front();
        end else begin
          m_row   = 0;
          cur     = read_outs(0);
          m_phase = MRead;
        end
      end
      MRead: begin
        if (buf_ready) begin
          if (m_row == ROWS - 1) begin
            cur = '0; cur.frame_done = 1'b1; cur.busy = 1'b1;
            m_phase = MDone;
          end else begin
            m_row++;
            cur = read_outs(m_row);
          end
        end
      end
      default: begin
        cur = '0;
        m_phase = MIdle;
      end
    endcase
  endfunction

  task automatic compare();
    outs_t act;
    act = {erase, expose, convert, adc_count, row_valid, row_sel, frame_done, busy};
    checks++;
    if (act !== cur) begin
      errors++;
      $display("FAIL outputs cycle %0d: got er=%b ex=%b cv=%b adc=%0d rv=%b rs=%0d fd=%b bz=%b, expected er=%b ex=%b cv=%b adc=%0d rv=%b rs=%0d fd=%b bz=%b",
               cyc, act.erase, act.expose, act.convert, act.adc, act.row_valid, act.row_sel,
               act.frame_done, act.busy, cur.erase, cur.expose, cur.convert, cur.adc,
               cur.row_valid, cur.row_sel, cur.frame_done, cur.busy);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  // One frame from IDLE with optional stall and a mid-exposure frame_req poke.
  task automatic run_frame(input vec_t v);
    int len, n_er, n_ex, n_cv, stall_left;
    bit seen, poked;
    frame_req  = 1'b1;
    exp_cycles = EXPW'(v.e);
    buf_ready  = 1'b1;
    step();
    frame_req  = 1'b0;
    exp_cycles = EXPW'($urandom);
    len = 0; n_er = 0; n_ex = 0; n_cv = 0;
    stall_left = v.stall_len; seen = 0; poked = 0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      len++;
      n_er += int'(erase);
      n_ex += int'(expose);
      n_cv += int'(convert);
      if (frame_done) begin
        seen = 1;
      end else begin
        frame_req = 1'b0;
        if (v.poke && expose && !poked) begin
          frame_req  = 1'b1;
          exp_cycles = EXPW'(50);
          poked      = 1;
        end
        buf_ready = 1'b1;
        if (row_valid && int'(row_sel) == v.stall_row && stall_left > 0) begin
          buf_ready = 1'b0;
          stall_left--;
        end
        step();
      end
    end
    check("frame_done_seen", seen, 1);
    check("frame_len", len, v.len);
    check("erase_cycles", n_er, ERASE);
    check("expose_cycles", n_ex, v.expose_n);
    check("convert_cycles", n_cv, 1 << ADCB);
    frame_req = 1'b0;
    step();
    check("busy_after_done", busy, 0);
    for (int i = 0; i < 3; i++) step();
    check("no_second_frame", busy, 0);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (frame_done) seen = 1;
      else step();
    end
    check(name, seen, 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{e: 10,  stall_row: -1, stall_len: 0, poke: 0, len: 276, expose_n: 10};
    vecs[1] = '{e: 0,   stall_row: -1, stall_len: 0, poke: 0, len: 267, expose_n: 1};
    vecs[2] = '{e: 1,   stall_row: -1, stall_len: 0, poke: 0, len: 267, expose_n: 1};
    vecs[3] = '{e: 10,  stall_row: 2,  stall_len: 7, poke: 0, len: 283, expose_n: 10};
    vecs[4] = '{e: 10,  stall_row: -1, stall_len: 0, poke: 1, len: 276, expose_n: 10};
    vecs[5] = '{e: 3,   stall_row: 0,  stall_len: 2, poke: 0, len: 271, expose_n: 3};
    vecs[6] = '{e: 300, stall_row: -1, stall_len: 0, poke: 0, len: 566, expose_n: 300};

    // Reset state, then release away from the clock edge.
    #3;
    compare();
    step();
    step();
    reset = 1'b1;
    step();
    check("reset_state_idle", dut.state_q, StIdle);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Held frame_req: back-to-back frames, erase resumes the cycle after IDLE.
    frame_req  = 1'b1;
    exp_cycles = EXPW'(2);
    buf_ready  = 1'b1;
    step();
    wait_done("b2b_first_done");
    step();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_erase", erase, 0);
    step();
    check("b2b_next_erase", erase, 1);
    check("b2b_next_busy", busy, 1);
    frame_req = 1'b0;
    wait_done("b2b_second_done");
    step();
    check("b2b_end_busy", busy, 0);

    // Asynchronous reset mid-conversion at adc_count=100.
    frame_req  = 1'b1;
    exp_cycles = EXPW'(1);
    step();
    frame_req = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 600 && !hit; c++) begin
        if (convert && adc_count == 8'd100) hit = 1;
        else step();
      end
      check("reached_adc_100", hit, 1);
    end
    #2;
    reset = 1'b0;
    model_edge();
    #1;
    compare();
    check("reset_no_frame_done", frame_done, 0);
    check("reset_busy_low", busy, 0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    run_frame(vecs[0]);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      frame_req  = ($urandom_range(0, 7) == 0);
      exp_cycles = EXPW'($urandom_range(0, 6));
      buf_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_sequencer.md
# sensor_sequencer

Frame-level controller for the pixel sensor array. Sequences each frame through erase, exposure, ramp-ADC conversion and row-by-row readout, and hands rows to the readout buffer over a valid/ready handshake. Sits between the system-level frame request and the pixel array / readout buffer inside the sensor top.

## Interface

Parameters:
- ROWS, PIXEL_ARRAY_HEIGHT (default 4): rows read out per frame.
- ADC_BITS, PIXEL_BITS (default 8): ramp counter width; conversion lasts 2^ADC_BITS cycles.
- ERASE_CYCLES, 5: erase phase length, ≥1.
- EXP_WIDTH, 16: width of the exposure-time input.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  main clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_req  in  1  request a frame; sampled only in IDLE.
- exp_cycles  in  EXP_WIDTH  exposure length in cycles; latched on frame accept; 0 treated as 1.
- buf_ready  in  1  readout buffer can accept a row.
- erase  out  1  pixel erase strobe.
- expose  out  1  pixel exposure enable.
- convert  out  1  ADC conversion active.
- adc_count  out  ADC_BITS  ramp/counter value broadcast to pixel latches.
- row_valid  out  1  row row_sel is driven onto the bus.
- row_sel  out  $clog2(ROWS)  row being read.
- frame_done  out  1  one-cycle pulse after last row transfer.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE → ERASE → EXPOSE → CONVERT → READ → DONE → IDLE.
- IDLE: all outputs 0. frame_req=1 at a clock edge → latch exp_cycles (0→1), enter ERASE.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles.
- EXPOSE: expose=1 for exactly the latched exposure count.
- CONVERT: convert=1 for 2^ADC_BITS cycles; adc_count = 0 in the first cycle, +1 each cycle, ends at 2^ADC_BITS−1; no wrap past that. adc_count returns to 0 on leaving CONVERT.
- READ: row_sel starts at 0; row_valid=1 throughout READ. A transfer occurs on any edge with row_valid && buf_ready; row_sel then increments. row_sel must stay stable while buf_ready=0 (no timeout). Transfer of row ROWS−1 → DONE.
- DONE: frame_done=1 for one cycle, busy=1, then IDLE.
- frame_req and exp_cycles are ignored outside IDLE; a held frame_req starts the next frame on the first IDLE edge.
- Phase outputs are mutually exclusive: at most one of erase/expose/convert/row_valid is high in any cycle.

## Timing

- All outputs registered; reset values: erase=expose=convert=row_valid=frame_done=busy=0, adc_count=0, row_sel=0, state IDLE.
- Reset assertion mid-frame: all outputs to reset values immediately (asynchronously); frame is abandoned with no frame_done. Release is synchronous to clk; first frame_req is sampled on the first edge after release.
- Latency: frame_req accepted at edge N → erase=1 from edge N (visible cycle N+1).
- With buf_ready held at 1, frame length from first erase cycle to frame_done cycle inclusive = ERASE_CYCLES + exp + 2^ADC_BITS + ROWS + 1 cycles.
- busy rises together with erase, falls the cycle after frame_done.

## Structure

- PixelSensorConfig package: PIXEL_BITS, PIXEL_ARRAY_HEIGHT (parameter defaults), plus a sequencer state enum typedef (IDLE, ERASE, EXPOSE, CONVERT, READ, DONE) shared with the bench for state checks.
- One sub-module: phase_counter: loadable down-counter with terminal-count flag, reused for the ERASE/EXPOSE/CONVERT durations. adc_count and row_sel are local up-counters.

## Test plan

- Reset then frame_req=1 for one cycle, exp_cycles=10, buf_ready=1 → erase 5 cycles, expose 10, convert 256 with adc_count 0..255, row_sel 0,1,2,3 one cycle each, frame_done at cycle 276, busy drops next cycle.
- exp_cycles=0 → expose high exactly 1 cycle.
- buf_ready low for 7 cycles on row 2 → row_valid held, row_sel stays 2, no extra transfer; totals shift by 7.
- frame_req pulsed during EXPOSE with different exp_cycles → ignored; current exposure unchanged, no second frame.
- frame_req held high → back-to-back frames; next erase starts the cycle after IDLE is entered.
- reset driven low mid-CONVERT (adc_count=100) → all outputs 0 without waiting for a clock edge, no frame_done; after release, a new frame runs the full sequence correctly.
